// File: rtl/alu_share_arb.sv
// Two-requester arbiter that time-shares one combinational ALU and returns results over a valid/ready response channel.
// Optional per-requester architectural flag registers are enabled with `define ALU_ARB_FLAGS_EN.
module alu_share_arb #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_v,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_z,
    output logic              resp_n,
    output logic              resp_v,
    output logic              busy
`ifdef ALU_ARB_FLAGS_EN
   ,output logic [2:0]        flags0,
    output logic [2:0]        flags1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last_grant;
    logic   grant0, grant1;
    logic   accept0, accept1;
    logic   resp_fire;

    // Arbitration; last_grant resets to 1 so requester 0 wins the first contention.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = (FIXED_PRIO != 0) ? 1'b1 : last_grant;
            grant1 = ~grant0;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
        req0_ready = (state == IDLE) && grant0;
        req1_ready = (state == IDLE) && grant1;
        accept0    = req0_ready && req0_valid;
        accept1    = req1_ready && req1_valid;
        resp_fire  = (state == RESP) && resp_ready;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept0 || accept1) state_next = EXEC;
            EXEC: state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand registers feed the ALU directly, so its inputs only change on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            resp_id    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept0) begin
            alu_a      <= req0_a;
            alu_b      <= req0_b;
            alu_op     <= req0_op;
            resp_id    <= 1'b0;
            last_grant <= 1'b0;
        end else if (accept1) begin
            alu_a      <= req1_a;
            alu_b      <= req1_b;
            alu_op     <= req1_op;
            resp_id    <= 1'b1;
            last_grant <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_z    <= 1'b0;
            resp_n    <= 1'b0;
            resp_v    <= 1'b0;
        end else if (state == EXEC) begin
            resp_data <= alu_out;
            resp_z    <= alu_z;
            resp_n    <= alu_n;
            resp_v    <= alu_v;
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

`ifdef ALU_ARB_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags0 <= '0;
            flags1 <= '0;
        end else if (resp_fire) begin
            if (resp_id) flags1 <= {resp_z, resp_n, resp_v};
            else         flags0 <= {resp_z, resp_n, resp_v};
        end
    end
`else
    logic unused_fire;
    assign unused_fire = resp_fire;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: round-robin and fixed-priority instances share stimulus, each with a stub add/sub ALU.
module tb_alu_share_arb;
    localparam int DW = 16;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OW-1:0] req0_op = '0, req1_op = '0;
    logic          resp_ready = 1'b1;

    logic          req0_ready, req1_ready, resp_valid, resp_id, resp_z, resp_n, resp_v, busy;
    logic [DW-1:0] alu_a, alu_b, alu_out, resp_data;
    logic [OW-1:0] alu_op;
    logic          alu_z, alu_n, alu_v;

    logic          f_req0_ready, f_req1_ready, f_resp_valid, f_resp_id, f_resp_z, f_resp_n, f_resp_v, f_busy;
    logic [DW-1:0] f_alu_a, f_alu_b, f_alu_out, f_resp_data;
    logic [OW-1:0] f_alu_op;
    logic          f_alu_z, f_alu_n, f_alu_v;
`ifdef ALU_ARB_FLAGS_EN
    logic [2:0]    flags0, flags1, f_flags0, f_flags1;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Stub ALU: op0 = a+b, op1 = a-b, otherwise a&b; flags per 16-bit two's complement.
    function automatic logic [DW+2:0] stub_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [OW-1:0] op);
        logic [DW-1:0] r;
        logic          v;
        case (op)
            4'd0: begin r = a + b; v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
            4'd1: begin r = a - b; v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
            default: begin r = a & b; v = 1'b0; end
        endcase
        return {r, (r == '0), r[DW-1], v};
    endfunction

    assign {alu_out, alu_z, alu_n, alu_v}         = stub_alu(alu_a, alu_b, alu_op);
    assign {f_alu_out, f_alu_z, f_alu_n, f_alu_v} = stub_alu(f_alu_a, f_alu_b, f_alu_op);

    alu_share_arb #(.DATA_W(DW), .OP_W(OW), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_z(resp_z), .resp_n(resp_n), .resp_v(resp_v), .busy(busy)
`ifdef ALU_ARB_FLAGS_EN
       ,.flags0(flags0), .flags1(flags1)
`endif
    );

    alu_share_arb #(.DATA_W(DW), .OP_W(OW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op), .alu_out(f_alu_out),
        .alu_z(f_alu_z), .alu_n(f_alu_n), .alu_v(f_alu_v),
        .resp_valid(f_resp_valid), .resp_ready(resp_ready), .resp_id(f_resp_id), .resp_data(f_resp_data),
        .resp_z(f_resp_z), .resp_n(f_resp_n), .resp_v(f_resp_v), .busy(f_busy)
`ifdef ALU_ARB_FLAGS_EN
       ,.flags0(f_flags0), .flags1(f_flags1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
        logic [DW-1:0] data;
        logic          z, n, v;
    } vec_t;

    // One isolated transaction with resp_ready held high; checks accept, exec and response cycles.
    task automatic do_op(input vec_t t);
        @(negedge clk);
        if (t.id) begin
            req1_valid = 1'b1; req1_a = t.a; req1_b = t.b; req1_op = t.op;
        end else begin
            req0_valid = 1'b1; req0_a = t.a; req0_b = t.b; req0_op = t.op;
        end
        #1;
        chk("accept_ready0", {31'd0, req0_ready}, {31'd0, ~t.id});
        chk("accept_ready1", {31'd0, req1_ready}, {31'd0, t.id});
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("exec_alu_a", {16'd0, alu_a}, {16'd0, t.a});
        chk("exec_alu_b", {16'd0, alu_b}, {16'd0, t.b});
        chk("exec_alu_op", {28'd0, alu_op}, {28'd0, t.op});
        chk("exec_no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_data", {16'd0, resp_data}, {16'd0, t.data});
        chk("resp_id", {31'd0, resp_id}, {31'd0, t.id});
        chk("resp_flags", {29'd0, resp_z, resp_n, resp_v}, {29'd0, t.z, t.n, t.v});
        @(negedge clk);
        chk("resp_drop", {31'd0, resp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 16'd5,    16'd2,    4'd1, 16'd3,    1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 16'd3,    16'd3,    4'd1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'd0,    16'd1,    4'd1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'h8000, 16'h8000, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 4'd1, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", {16'd0, resp_data}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) do_op(vecs[i]);

        // Reset while in EXEC discards the operation
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd4; req0_op = 4'd0;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_resp_data", {16'd0, resp_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end

        // Contention: both valid continuously; round-robin vs fixed priority
        do_reset();
        begin
            int g = 0;
            int r = 0;
            int fg = 0;
            req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd1; req0_op = 4'd0;
            req1_valid = 1'b1; req1_a = 16'd2; req1_b = 16'd2; req1_op = 4'd0;
            for (int c = 0; c < 12; c++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    chk("rr_grant", {31'd0, req1_ready}, {31'd0, g[0]});
                    g++;
                end
                if (resp_valid) begin
                    chk("rr_resp_id", {31'd0, resp_id}, {31'd0, r[0]});
                    chk("rr_resp_data", {16'd0, resp_data}, r[0] ? 32'd4 : 32'd2);
                    r++;
                end
                if (f_req1_ready) chk("fp_req1_ready", 32'd1, 32'd0);
                if (f_req0_ready) fg++;
                if (f_resp_valid) chk("fp_resp_data", {15'd0, f_resp_id, f_resp_data}, 32'd2);
                @(negedge clk);
            end
            chk("rr_grant_count", g, 4);
            chk("rr_resp_count", r, 4);
            chk("fp_grant_count", fg, 4);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end

        // Backpressure: response held, no acceptance while stalled
        do_reset();
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd10; req1_b = 16'd3; req1_op = 4'd1;
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd7; req0_op = 4'd0;
        begin
            int waited = 0;
            while (!resp_valid && waited < 10) begin @(negedge clk); waited++; end
            chk("bp_resp_arrives", {31'd0, resp_valid}, 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_data", {16'd0, resp_data}, 32'd7);
            chk("bp_id", {31'd0, resp_id}, 32'd1);
            chk("bp_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_release_idle", {30'd0, busy, resp_valid}, 32'd0);

`ifdef ALU_ARB_FLAGS_EN
        // Flag registers: only the issuing requester's register loads
        do_reset();
        chk("flags_rst", {26'd0, flags0, flags1}, 32'd0);
        do_op(vecs[1]);
        chk("flags1_ovf", {29'd0, flags1}, 32'b011);
        chk("flags0_kept", {29'd0, flags0}, 32'd0);
        do_op(vecs[2]);
        chk("flags0_zero", {29'd0, flags0}, 32'b100);
        chk("flags1_kept", {29'd0, flags1}, 32'b011);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single 16-bit combinational ALU (operands a/b, 4-bit ALUControl, z/n/v flags) between two requesters, e.g. execute stage and address-generation/cache-side logic.
- Arbitrates with round-robin or fixed priority and drives the ALU from registered operands.
- Captures the result and flags into registers and returns them through a valid/ready response channel tagged with the requester id.

Parameters:
- DATA_W, 16, operand/result width; must match ALU
- OP_W, 4, ALU control width
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins when both valid

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  DATA_W  operand a
- req0_b  in  DATA_W  operand b
- req0_op  in  OP_W  ALU control
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0
- alu_a  out  DATA_W  to ALU a
- alu_b  out  DATA_W  to ALU b
- alu_op  out  OP_W  to ALU ALUControl
- alu_out  in  DATA_W  ALU result
- alu_z, alu_n, alu_v  in  1  ALU flags
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that issued the result
- resp_data  out  DATA_W  registered result
- resp_z, resp_n, resp_v  out  1  registered flags
- busy  out  1  state != IDLE

Behaviour:
- FSM states IDLE, EXEC, RESP; reset state IDLE.
- Reset (async, rst_n=0): all registered outputs 0 (alu_a/b/op, resp_*, busy); last_grant=1, so requester 0 wins first. Reset mid-operation discards the operation; no response is produced.
- IDLE, arbitration:
  - Grant goes to the only valid requester.
  - If both are valid: grant = ~last_grant (round-robin), or requester 0 when FIXED_PRIO=1.
  - reqX_ready = (state==IDLE) & grantX, combinational. The non-granted ready is 0.
  - On valid&ready: latch a/b/op into operand regs, latch id, update last_grant, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (1 cycle):
  - alu_a/alu_b/alu_op come from the operand regs (stable the whole cycle).
  - At the clock edge: capture alu_out and alu_z/n/v into resp regs, go to RESP.
- RESP:
  - resp_valid=1. resp_data/id/flags held stable until resp_ready=1.
  - On handshake: resp_valid drops next cycle, return to IDLE.
  - No new request is accepted in EXEC or RESP.
- Latency:
  - Acceptance edge to resp_valid high = 2 cycles.
  - Minimum spacing between acceptances = 3 cycles (accept, exec, resp with resp_ready=1).
- ALU inputs retain their last operand values outside EXEC (no toggling in IDLE).
- Requester may deassert valid before acceptance with no effect. Payload must be held stable while valid & !ready.
- No arithmetic is performed in this block; widths pass straight through.

Optional Feature:
- Macro: ALU_ARB_FLAGS_EN.
- Enabled:
  - Adds outputs flags0 and flags1, each 3 bits, ordered {z,n,v}: per-requester architectural flag registers.
  - The issuing requester's register is loaded with resp_z/n/v on the response handshake; the other requester's register is unchanged.
  - Both reset to 0.
- Disabled: ports and registers absent; behaviour otherwise identical.

Test Plan:
Bench uses a stub ALU: op0 = a+b, op1 = a-b (z/n/v per 16-bit two's complement).
- Reset: assert rst_n=0 while in EXEC -> all outputs 0 immediately, state IDLE, no resp_valid afterwards.
- Single op: req0 a=5, b=2, op=1, resp_ready=1 -> req0_ready high in cycle 0; resp_valid high at cycle 2 with resp_data=3, resp_id=0, z=n=v=0.
- Contention: both requesters valid continuously after reset (req0 a=1,b=1,op0; req1 a=2,b=2,op0) -> grants alternate 0,1,0,1; resp_data alternates 2,4.
- Contention with FIXED_PRIO=1: same stimulus -> requester 0 granted every time; req1_ready never high.
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid, resp_data and resp_id stable; both reqX_ready stay 0; one cycle after release, state IDLE.
- Overflow plus flags: req1 a=16'h7FFF, b=16'h0001, op0 -> resp_data=16'h8000, n=1, v=1, z=0. With ALU_ARB_FLAGS_EN: flags1=3'b011 after handshake, flags0 unchanged at 3'b000.
